// File: rtl/stall_sched.sv
// stall_sched -- pipeline stall scheduler.
// Builds the 6-bit stall bus (PC, IF, ID, EX, MEM, WB) from two sources:
// a combinational load-use hazard detector between ID and EX, and a
// three-state sequencer that holds the front of the pipeline while a
// multi-cycle mult/div op occupies EX, then pulses md_finish.
// Optional build macro: STALL_SCHED_PERF_EN adds two 32-bit counters,
// perf_lu_cnt and perf_md_cnt, counting load-use and mult/div stall cycles.
`timescale 1ns/1ps

module stall_sched #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_is_load,
    input  logic       ex_rf_we,
    input  logic [4:0] ex_rf_waddr,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic [5:0] stall,
    output logic       md_busy,
    output logic       md_finish
`ifdef STALL_SCHED_PERF_EN
    ,
    output logic [31:0] perf_lu_cnt,
    output logic [31:0] perf_md_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stall patterns: load-use holds PC/IF/ID and bubbles EX; mult/div also holds EX.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_MD   = 6'b001111;

    // The start cycle and the final RUN cycle (cnt==0) both stall, hence the -2.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             ld_use;
    logic             md_stall;

    // Load-use hazard: EX load writing a nonzero register that ID is about to read.
    assign ld_use = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                    ((id_rs_used && (id_rs == ex_rf_waddr)) ||
                     (id_rt_used && (id_rt == ex_rf_waddr)));

    // State and countdown registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic; md_is_div only matters on the IDLE->RUN edge.
    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (md_start) begin
                    next_state = RUN;
                    next_cnt   = md_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end else begin
                    next_cnt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                // The finished op is still in EX, so md_start is ignored here.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs: mult/div stall (Mealy in IDLE) overrides load-use; all outputs are 0 during reset.
    always_comb begin
        md_stall  = 1'b0;
        md_busy   = 1'b0;
        md_finish = 1'b0;
        stall     = STALL_NONE;
        if (!rst) begin
            case (state)
                IDLE: begin
                    md_stall = md_start;
                    md_busy  = md_start;
                end
                RUN: begin
                    md_stall = 1'b1;
                    md_busy  = 1'b1;
                end
                DONE: begin
                    md_busy   = 1'b1;
                    md_finish = 1'b1;
                end
                default: begin
                    md_stall = 1'b0;
                end
            endcase
            if (md_stall) begin
                stall = STALL_MD;
            end else if (ld_use) begin
                stall = STALL_LU;
            end
        end
    end

`ifdef STALL_SCHED_PERF_EN
    // Wrap-around stall-cycle counters, one per stall source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_cnt <= '0;
            perf_md_cnt <= '0;
        end else begin
            if (stall == STALL_LU) begin
                perf_lu_cnt <= perf_lu_cnt + 32'd1;
            end
            if (stall == STALL_MD) begin
                perf_md_cnt <= perf_md_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stall_sched.sv
// tb_stall_sched -- self-checking bench for stall_sched.
// Reference model: an op timeline (start cycle + length) from which the
// stall/busy/finish outputs of every cycle are derived arithmetically.
// Define STALL_SCHED_PERF_EN for both files to exercise the perf counters.
`timescale 1ns/1ps

module tb_stall_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_is_load;
    logic       ex_rf_we;
    logic [4:0] ex_rf_waddr;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       md_start;
    logic       md_is_div;
    logic [5:0] stall;
    logic       md_busy;
    logic       md_finish;
`ifdef STALL_SCHED_PERF_EN
    logic [31:0] perf_lu_cnt;
    logic [31:0] perf_md_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference timeline: an op started in cycle op_t0 stalls cycles op_t0..op_t0+op_n-1
    // and finishes in cycle op_t0+op_n.
    int cyc       = 0;
    bit op_active = 1'b0;
    int op_t0     = 0;
    int op_n      = 0;

    stall_sched dut (
        .clk         (clk),
        .rst         (rst),
        .ex_is_load  (ex_is_load),
        .ex_rf_we    (ex_rf_we),
        .ex_rf_waddr (ex_rf_waddr),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .md_start    (md_start),
        .md_is_div   (md_is_div),
        .stall       (stall),
        .md_busy     (md_busy),
        .md_finish   (md_finish)
`ifdef STALL_SCHED_PERF_EN
        ,
        .perf_lu_cnt (perf_lu_cnt),
        .perf_md_cnt (perf_md_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {stall, md_busy, md_finish};
    endfunction

    function automatic bit model_ld_use();
        return ex_is_load && ex_rf_we && (ex_rf_waddr != 0) &&
               ((id_rs_used && id_rs == ex_rf_waddr) || (id_rt_used && id_rt == ex_rf_waddr));
    endfunction

    // Expected {stall, md_busy, md_finish} for the current cycle.
    function automatic logic [7:0] exp_vec();
        int  k;
        bit  md;
        bit  fin;
        logic [5:0] s;
        k   = cyc - op_t0;
        if (rst) return 8'h00;
        md  = (op_active && k < op_n) || (!op_active && md_start);
        fin = op_active && k == op_n;
        s   = md ? 6'b001111 : (model_ld_use() ? 6'b000111 : 6'b000000);
        return {s, op_active || md_start, fin};
    endfunction

    // Advance one clock and update the timeline; inputs may be driven on return.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            op_active = 1'b0;
        end else if (op_active) begin
            if (cyc - op_t0 == op_n) op_active = 1'b0;
        end else if (md_start) begin
            op_active = 1'b1;
            op_t0     = cyc;
            op_n      = md_is_div ? 33 : 4;
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        ex_is_load = 0; ex_rf_we = 0; ex_rf_waddr = 0;
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        md_start = 0; md_is_div = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        op_active = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] wa, input logic [4:0] rs, input logic rs_u,
                            input logic [4:0] rt, input logic rt_u);
        ex_is_load = 1; ex_rf_we = 1; ex_rf_waddr = wa;
        id_rs = rs; id_rs_used = rs_u; id_rt = rt; id_rt_used = rt_u;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        clear_inputs();
        rst = 1'b1;
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        md_start = 1'b1;
        #2;
        got = obs();
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", got, 8'h00);
        end
        @(posedge clk);
        #2;
        got = obs();
        n_tests++;
        if (got !== 8'h00 || dut.state !== 2'd0 || dut.cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: out %b state %0d cnt %0d want 0/0/0", got, dut.state, dut.cnt);
        end
        clear_inputs();
        rst = 1'b0;
        op_active = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        logic [5:0] want [4];
        logic [5:0] got;
        want = '{6'b000111, 6'b000000, 6'b000000, 6'b000111};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
                1: set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
                2: set_load(5'd7, 5'd0, 1'b0, 5'd7, 1'b0);
                default: set_load(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
            endcase
            @(negedge clk);
            got = stall;
            n_tests++;
            if (got !== want[i] || md_busy !== 1'b0 || md_finish !== 1'b0) begin
                n_fail++;
                $display("FAIL load_use_%0d: stall %b busy %b fin %b want %b/0/0",
                         i, got, md_busy, md_finish, want[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    // Runs one op from IDLE; returns stall-cycle count, finish cycle index and busy after finish.
    task automatic run_op(input string tag, input logic div, input bit lu_at_start,
                          output int stalls, output int fin_at, output logic busy_after);
        logic [7:0] got, want;
        int total;
        total = div ? 36 : 7;
        stalls = 0; fin_at = 0; busy_after = 1'bx;
        clear_inputs();
        md_start = 1'b1; md_is_div = div;
        if (lu_at_start) set_load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            got  = obs();
            want = exp_vec();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b want %b", tag, c, got, want);
            end
            if (stall == 6'b001111) stalls++;
            if (md_finish === 1'b1) fin_at = c;
            if (c == total - 1) busy_after = md_busy;
            tick();
            if (c == 1) begin
                clear_inputs();
                md_is_div = ~div;
            end
        end
    endtask

    task automatic test_div();
        int s, f;
        logic b;
        run_op("div", 1'b1, 1'b0, s, f, b);
        n_tests++;
        if (s != 33 || f != 34 || b !== 1'b0) begin
            n_fail++;
            $display("FAIL div_timing: stalls %0d fin %0d busy35 %b want 33/34/0", s, f, b);
        end
    endtask

    task automatic test_mult_ld_use();
        int s, f;
        logic b;
        run_op("mult", 1'b0, 1'b1, s, f, b);
        n_tests++;
        if (s != 4 || f != 5 || b !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_timing: stalls %0d fin %0d busy6 %b want 4/5/0", s, f, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int s, f;
        logic b;
        clear_inputs();
        md_start = 1'b1; md_is_div = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) begin
                n_tests++;
                if (stall !== 6'b001111) begin
                    n_fail++;
                    $display("FAIL reset_mid_pre: stall %b want 001111", stall);
                end
                #1 rst = 1'b1;
                #1 got = obs();
                n_tests++;
                if (got !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_mid_async: got %b want %b", got, 8'h00);
                end
                op_active = 1'b0;
                #1 rst = 1'b0;
            end
            tick();
            if (c == 1) clear_inputs();
        end
        run_op("div_restart", 1'b1, 1'b0, s, f, b);
        n_tests++;
        if (s != 33 || f != 34) begin
            n_fail++;
            $display("FAIL reset_mid_restart: stalls %0d fin %0d want 33/34", s, f);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, want;
        for (int c = 0; c < 400; c++) begin
            ex_is_load  = ($urandom_range(0, 3) != 0);
            ex_rf_we    = ($urandom_range(0, 3) != 0);
            ex_rf_waddr = 5'($urandom_range(0, 3));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_rs_used  = 1'($urandom_range(0, 1));
            id_rt_used  = 1'($urandom_range(0, 1));
            md_start    = ($urandom_range(0, 5) == 0);
            md_is_div   = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            got  = obs();
            want = exp_vec();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b want %b", c, got, want);
            end
            tick();
        end
        clear_inputs();
        for (int c = 0; c < 40; c++) tick();
    endtask

`ifdef STALL_SCHED_PERF_EN
    task automatic test_perf();
        int s, f;
        logic b;
        apply_reset();
        clear_inputs();
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        tick();
        run_op("perf_mult", 1'b0, 1'b1, s, f, b);
        n_tests++;
        if (perf_lu_cnt !== 32'd1 || perf_md_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL perf_counts: lu %0d md %0d want 1/4", perf_lu_cnt, perf_md_cnt);
        end
        @(negedge clk);
        force dut.perf_md_cnt = 32'hFFFF_FFFC;
        #1 release dut.perf_md_cnt;
        tick();
        run_op("perf_wrap", 1'b0, 1'b0, s, f, b);
        n_tests++;
        if (perf_md_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_wrap: md %h want 00000000", perf_md_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_div();
        test_mult_ld_use();
        test_reset_mid();
        test_random();
`ifdef STALL_SCHED_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1);
    end

endmodule
